// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Multicycle control unit for the 8-bit CPU datapath. Decodes the
//   instruction register byte and walks one FSM state per clock. Each state
//   drives the datapath load, select, write and ALU-function strobes.
//
//   Instruction lengths and cycle counts:
//     ALU 1 byte, 4 cycles    LD 3 bytes, 6 cycles    ST 3 bytes, 5 cycles
//     JMP 3 bytes, 5 cycles   NOP 1 byte, 2 cycles
//
//   Optional feature macro: CTRL_HALT_EN
//     defined   : op 011 enters HALT. HALT is sticky until rst.
//     undefined : op 011 is a 2-cycle NOP. halted is tied 0.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   IRout[7:0]      instruction register contents
//   IRld..CZNld     register load enables
//   pcWrite         PC load
//   jmpsignal       conditional-jump request (datapath ANDs it with the flag)
//   IorD            memory address select (0 = PC, 1 = TR)
//   memoryread/write  memory strobes
//   RA2Sel, WASel   register address select (0 = IR[3:2], 1 = DI[4:3])
//   WDSel           register write data (0 = MDR, 1 = ALU register)
//   ALU1Sel         0 = B, 1 = 8'h00
//   ALU2Sel         0 = MDR, 1 = A
//   RegWrite        register file write enable
//   fun[1:0]        ALU function
//   halted          core stopped
//
// The outputs are a pure decode of the state register. They are forced to 0
// while rst is high. This makes reset silence the strobes at once, and lets
// FETCH strobes show in the very first cycle after rst falls.
// -----------------------------------------------------------------------------
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] IRout,
   output logic       IRld,
   output logic       DIld,
   output logic       TRld,
   output logic       MDRld,
   output logic       CZNld,
   output logic       pcWrite,
   output logic       jmpsignal,
   output logic       IorD,
   output logic       memoryread,
   output logic       memorywrite,
   output logic       RA2Sel,
   output logic       WASel,
   output logic       WDSel,
   output logic       ALU1Sel,
   output logic       ALU2Sel,
   output logic       RegWrite,
   output logic [1:0] fun,
   output logic       halted
);

   typedef enum logic [3:0] {
      FETCH, DECODE, ALU_EX, ALU_WB, FA1, FA2,
      LD_MEM, LD_WB, ST_MEM, JMP, HALT
   } state_e;

   localparam logic [2:0] OP_LD  = 3'b000;
   localparam logic [2:0] OP_ST  = 3'b001;
   localparam logic [2:0] OP_JMP = 3'b010;

`ifdef CTRL_HALT_EN
   localparam state_e NOP_NEXT = HALT;
`else
   localparam state_e NOP_NEXT = FETCH;
`endif

   state_e     state_q, state_d;
   logic [2:0] op_q, op_d;     // byte1 overwrites IR, so FA2 needs a copy of op

   // Only IR[7:5] is decoded here. The operand fields are consumed by the datapath.
   logic unused_ir;
   assign unused_ir = ^IRout[4:0];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      unique case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            op_d = IRout[7:5];
            if (IRout[7])                state_d = ALU_EX;
            else if (IRout[6:5] == 2'b11) state_d = NOP_NEXT;
            else                         state_d = FA1;
         end
         ALU_EX: state_d = ALU_WB;
         ALU_WB: state_d = FETCH;
         FA1:    state_d = FA2;
         FA2: begin
            case (op_q)
               OP_LD:   state_d = LD_MEM;
               OP_ST:   state_d = ST_MEM;
               OP_JMP:  state_d = JMP;
               default: state_d = FETCH;
            endcase
         end
         LD_MEM: state_d = LD_WB;
         LD_WB:  state_d = FETCH;
         ST_MEM: state_d = FETCH;
         JMP:    state_d = FETCH;
         HALT:   state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= 3'b000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      IRld = 1'b0; DIld = 1'b0; TRld = 1'b0; MDRld = 1'b0; CZNld = 1'b0;
      pcWrite = 1'b0; jmpsignal = 1'b0; IorD = 1'b0;
      memoryread = 1'b0; memorywrite = 1'b0;
      RA2Sel = 1'b0; WASel = 1'b0; WDSel = 1'b0;
      ALU1Sel = 1'b0; ALU2Sel = 1'b0; RegWrite = 1'b0;
      fun = 2'b00; halted = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH, FA1: begin
               memoryread = 1'b1; IRld = 1'b1; pcWrite = 1'b1;
            end
            DECODE: DIld = 1'b1;
            ALU_EX: begin
               ALU2Sel = 1'b1; CZNld = 1'b1; fun = IRout[6:5];
            end
            ALU_WB: begin
               RegWrite = 1'b1; WDSel = 1'b1;
            end
            FA2: begin
               memoryread = 1'b1; TRld = 1'b1; RA2Sel = 1'b1;
               pcWrite    = (op_q != OP_JMP);  // JMP keeps PC on byte2 for the not-taken +1
            end
            LD_MEM: begin
               IorD = 1'b1; memoryread = 1'b1; MDRld = 1'b1;
            end
            LD_WB: begin
               RegWrite = 1'b1; WASel = 1'b1;
            end
            ST_MEM: begin
               IorD = 1'b1; memorywrite = 1'b1; RA2Sel = 1'b1;
            end
            JMP: begin
               jmpsignal = 1'b1; pcWrite = 1'b1;
            end
`ifdef CTRL_HALT_EN
            HALT: halted = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Each instruction byte0 is expanded into the list of strobe sets the
//   controller should show, one per cycle. Every cycle of the DUT is
//   compared against that list. Directed instructions come first, followed
//   by randomly chosen opcodes. IRout carries random junk in every cycle
//   where it is don't-care.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] IRout = 8'h00;
   logic       IRld, DIld, TRld, MDRld, CZNld, pcWrite, jmpsignal, IorD;
   logic       memoryread, memorywrite, RA2Sel, WASel, WDSel, ALU1Sel, ALU2Sel;
   logic       RegWrite, halted;
   logic [1:0] fun;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // bit positions inside the 19-bit strobe vector
   localparam int IRLD = 18, DILD = 17, TRLD = 16, MDRLD = 15, CZN = 14;
   localparam int PCW = 13, JMPS = 12, IORD = 11, MRD = 10, MWR = 9;
   localparam int RA2 = 8, WAS = 7, WDS = 6, A1S = 5, A2S = 4, RGW = 3;
   localparam int HLT = 0;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .IRout(IRout),
      .IRld(IRld), .DIld(DIld), .TRld(TRld), .MDRld(MDRld), .CZNld(CZNld),
      .pcWrite(pcWrite), .jmpsignal(jmpsignal), .IorD(IorD),
      .memoryread(memoryread), .memorywrite(memorywrite),
      .RA2Sel(RA2Sel), .WASel(WASel), .WDSel(WDSel),
      .ALU1Sel(ALU1Sel), .ALU2Sel(ALU2Sel), .RegWrite(RegWrite),
      .fun(fun), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] obs_vec();
      return {IRld, DIld, TRld, MDRld, CZNld, pcWrite, jmpsignal, IorD,
              memoryread, memorywrite, RA2Sel, WASel, WDSel, ALU1Sel,
              ALU2Sel, RegWrite, fun, halted};
   endfunction

   function automatic logic [18:0] bits(input int a, input int b = -1,
                                        input int c = -1, input int d = -1);
      logic [18:0] v;
      v = '0;
      v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      if (d >= 0) v[d] = 1'b1;
      return v;
   endfunction

   task automatic check(input string tag, input int cyc, input logic [18:0] exp);
      logic [18:0] obs;
      obs = obs_vec();
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cycle %0d: got %05h, expected %05h", tag, cyc, obs, exp);
      end
   endtask

   // Expected strobe sequence for one instruction, from the opcode table.
   task automatic build(input logic [7:0] b0, output logic [18:0] q[$]);
      logic [18:0] v;
      logic [2:0]  op;
      op = b0[7:5];
      q = {};
      q.push_back(bits(MRD, IRLD, PCW));                    // FETCH
      q.push_back(bits(DILD));                              // DECODE
      if (b0[7]) begin
         v = bits(A2S, CZN);
         v[2:1] = b0[6:5];
         q.push_back(v);                                    // ALU_EX
         q.push_back(bits(RGW, WDS));                       // ALU_WB
      end else if (op == 3'b011) begin
`ifdef CTRL_HALT_EN
         for (int i = 0; i < 20; i++) q.push_back(bits(HLT));
`endif
      end else begin
         q.push_back(bits(MRD, IRLD, PCW));                 // FA1
         v = bits(MRD, TRLD, RA2);
         if (op != 3'b010) v[PCW] = 1'b1;
         q.push_back(v);                                    // FA2
         if (op == 3'b000) begin
            q.push_back(bits(IORD, MRD, MDRLD));
            q.push_back(bits(RGW, WAS));
         end else if (op == 3'b001) begin
            q.push_back(bits(IORD, MWR, RA2));
         end else begin
            q.push_back(bits(JMPS, PCW));
         end
      end
   endtask

   // Entered at posedge+1 with FETCH current. When ncyc cuts the instruction
   // short, it returns before the following edge so that the caller can reset
   // from inside that state.
   task automatic run_instr(input logic [7:0] b0, input string tag, input int ncyc = 0);
      logic [18:0] q[$];
      int n;
      build(b0, q);
      n = (ncyc > 0 && ncyc < q.size()) ? ncyc : q.size();
      for (int i = 0; i < n; i++) begin
         if (i == 1 || (i == 2 && b0[7])) IRout = b0;
         else                             IRout = 8'($urandom);
         @(negedge clk);
         check(tag, i + 1, q[i]);
         if (i < n - 1 || n == q.size()) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      logic [7:0] b;
      logic [2:0] op;

      // power-on reset, outputs must be silent
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", i, '0);
      end
      @(posedge clk); #1 rst = 1'b0;

      run_instr(8'hA6, "alu_a6");
      run_instr(8'h10, "ld_10");
      run_instr(8'h38, "st_38");
      run_instr(8'h42, "jmp_42");
      run_instr(8'h40, "jmp_40");
      run_instr(8'hFF, "alu_ff");
`ifndef CTRL_HALT_EN
      run_instr(8'h60, "nop_60");
      run_instr(8'h7F, "nop_7f");
`endif

      // abort ST while in FA2, with the memory write due on the next edge
      run_instr(8'h38, "st_abort", 4);
      #2 rst = 1'b1;
      #1 check("rst_async", 0, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_pending_wr", i, '0);
      end
      @(posedge clk); #1 rst = 1'b0;
      run_instr(8'h01, "ld_after_rst");

      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom_range(0, 7));
`ifdef CTRL_HALT_EN
         if (op == 3'b011) op = 3'b010;
`endif
         b = {op, 5'($urandom)};
         run_instr(b, "random");
      end

`ifdef CTRL_HALT_EN
      run_instr(8'h60, "halt_60");
      rst = 1'b1;
      #1 check("halt_rst", 0, '0);
      @(posedge clk); #1 rst = 1'b0;
      run_instr(8'hA6, "alu_after_halt");
`endif

      @(negedge clk);
      check("final_fetch", 0, bits(MRD, IRLD, PCW));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the 8-bit CPU datapath. Sits directly upstream of the datapath. It consumes the instruction register byte `IRout` and produces every datapath load, select, write and ALU-function strobe, one FSM state per clock. Instructions are 1 or 3 bytes and execute in 2–6 cycles.

## Interface
- none (no parameters)

- `clk`  in  1  datapath clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `IRout`  in  8  instruction register contents
- `IRld`, `DIld`, `TRld`, `MDRld`, `CZNld`  out  1  register load enables
- `pcWrite`  out  1  PC load
- `jmpsignal`  out  1  conditional-jump request; the datapath ANDs it with the flag selected by DI[1:0]
- `IorD`  out  1  memory address select: 0 = PC, 1 = TR
- `memoryread`, `memorywrite`  out  1  memory strobes
- `RA2Sel`, `WASel`  out  1  register address select: 0 = IR[3:2], 1 = DI[4:3]
- `WDSel`  out  1  register write data: 0 = MDR, 1 = ALU register
- `ALU1Sel`  out  1  0 = B, 1 = 8'h00
- `ALU2Sel`  out  1  0 = MDR, 1 = A
- `RegWrite`  out  1  register file write enable
- `fun`  out  2  ALU function
- `halted`  out  1  core stopped; tied 0 unless `CTRL_HALT_EN`

## Operation
- Encoding of byte0: `op` = IR[7:5], `reg` = IR[4:3], `cond` = IR[1:0].
  - `1ff`: ALU Rd(IR[3:2]) <= Rd op Rs(IR[1:0]). `fun` = IR[6:5]. 1 byte.
  - `000`: LD R[reg] <= M[addr]. 3 bytes.
  - `001`: ST M[addr] <= R[reg]. 3 bytes.
  - `010`: JMP cond, addr. 3 bytes.
  - `011`: NOP, or HALT (see Configuration). 1 byte.
  - For 3-byte instructions, addr = {byte1[4:0], byte2}.
- Internal 3-bit opcode register, loaded in DECODE. It is needed because byte1 overwrites IR.
- Moore FSM. Any output not listed for a state is 0.
  - FETCH: `memoryread`, `IRld`, `pcWrite`. Next: DECODE.
  - DECODE: `DIld`, latch op. Next: IR[7] → ALU_EX; op 000/001/010 → FA1; op 011 → FETCH.
  - ALU_EX: `ALU2Sel`=1, `fun`=IR[6:5], `CZNld`. Next: ALU_WB.
  - ALU_WB: `RegWrite`, `WDSel`=1, `WASel`=0. Next: FETCH.
  - FA1: `memoryread`, `IRld`, `pcWrite`. Next: FA2.
  - FA2: `memoryread`, `TRld`, `RA2Sel`=1. `pcWrite`=1 unless op = 010. Next: LD_MEM, ST_MEM or JMP.
  - LD_MEM: `IorD`, `memoryread`, `MDRld`. Next: LD_WB.
  - LD_WB: `RegWrite`, `WASel`=1, `WDSel`=0. Next: FETCH.
  - ST_MEM: `IorD`, `memorywrite`, `RA2Sel`=1. Next: FETCH.
  - JMP: `jmpsignal`, `pcWrite`. Taken → PC <= TR; not taken → PC <= PC+1. Next: FETCH.
  - HALT (macro only): all strobes 0, `halted`=1. Remains until `rst`.
- `fun` = IR[6:5] in ALU_EX and 2'b00 elsewhere.
- `cond` = 00 is a never-taken jump, i.e. a 3-byte no-op.

## Timing
- Cycle counts: ALU 4, LD 6, ST 5, JMP 5, NOP 2.
- While `rst`=1, the state forces to FETCH and every output is 0, including `memorywrite` and `pcWrite`. The first FETCH strobes appear in the first cycle after `rst` falls.
- `rst` asserted mid-instruction aborts it immediately; no partial write is issued after the `rst` edge.
- RegA and RegB load every cycle. The operands therefore reflect addresses driven in the preceding state: DECODE for ALU, FA2 for ST.
- `IRout` is sampled only in DECODE and ALU_EX. Its value in other states is don't-care.

## Configuration
- `CTRL_HALT_EN` defined:
  - op 011 in DECODE → HALT.
  - `halted` goes to 1 in the HALT cycle.
  - PC has already advanced past the HALT byte.
- `CTRL_HALT_EN` undefined:
  - op 011 is a 2-cycle NOP.
  - `halted` is constant 0.

## Test plan
- Reset: hold `rst` 3 cycles with a write-causing state pending → all outputs 0. First cycle after release shows `memoryread`=`IRld`=`pcWrite`=1.
- ALU, IR=8'hA6 (op 101, Rd=R1, Rs=R2) → DECODE `DIld`; ALU_EX `fun`=01, `ALU2Sel`=1, `CZNld`=1; ALU_WB `RegWrite`=1, `WDSel`=1, `WASel`=0; back in FETCH on cycle 5.
- LD, bytes 8'h10, 8'h01, 8'h23 → FA2 `TRld`=1 and `pcWrite`=1; LD_MEM `IorD`=`MDRld`=1; LD_WB `WASel`=1, `WDSel`=0, `RegWrite`=1. 6 cycles total.
- ST, byte0 8'h38 → FA2 `RA2Sel`=1; ST_MEM `memorywrite`=1, `IorD`=1, `memoryread`=0. 5 cycles.
- JMP, byte0 8'h42 → FA2 `pcWrite`=0; JMP `jmpsignal`=`pcWrite`=1. Repeat with byte0 8'h40: same strobes.
- IR=8'h60:
  - with `CTRL_HALT_EN`: `halted`=1 from cycle 3 and no further strobes for 20 cycles; `rst` clears it.
  - without the macro: FETCH again on cycle 3.
